// File: rtl/xgmii_pkg.sv
// Shared XGMII framing constants, header beat indices and TX state encoding.
// Used by the transmit engine and by the receive-side parser.
package xgmii_pkg;

  localparam logic [7:0] XgStart = 8'hFB;
  localparam logic [7:0] XgTerm  = 8'hFD;
  localparam logic [7:0] XgIdle  = 8'h07;
  localparam logic [7:0] XgErr   = 8'hFE;
  localparam logic [7:0] XgPre   = 8'h55;
  localparam logic [7:0] XgSfd   = 8'hD5;

  localparam logic [63:0] IdleBeat = {8{XgIdle}};
  localparam logic [63:0] ErrBeat  = {8{XgErr}};

  localparam logic [15:0] EthTypeIpv4 = 16'h0800;
  localparam logic [7:0]  IpProtoUdp  = 8'h11;

  // Index into the eight header beats (wire beats 1..8)
  localparam logic [2:0] BeatMac    = 3'd0;
  localparam logic [2:0] BeatMacEth = 3'd1;
  localparam logic [2:0] BeatIp0    = 3'd2;
  localparam logic [2:0] BeatIp1    = 3'd3;
  localparam logic [2:0] BeatIpUdp  = 3'd4;
  localparam logic [2:0] BeatMagic  = 3'd5;
  localparam logic [2:0] BeatCmd    = 3'd6;
  localparam logic [2:0] BeatAddr   = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StCsum,
    StPre,
    StHdr,
    StPay,
    StFcs,
    StErr,
    StIfg
  } tx_state_e;

  // Wire-order value (first byte in the MSBs) to XGMII lane order (lane 0 in txd[7:0]).
  function automatic logic [63:0] wire2lanes(input logic [63:0] w);
    logic [63:0] l;
    for (int i = 0; i < 8; i++) begin
      l[8*i +: 8] = w[56-8*i +: 8];
    end
    return l;
  endfunction

endpackage

// File: rtl/crc32_d64.sv
// Ethernet CRC32 (reflected, poly 0xEDB88320) advanced by 64 data bits per call.
// Lane 0 bit 0 is consumed first; caller handles init and final inversion.
module crc32_d64 (
  input  logic [31:0] crc_i,
  input  logic [63:0] data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] Poly = 32'hEDB88320;

  logic [31:0] c;
  logic        fb;

  always_comb begin
    c  = crc_i;
    fb = 1'b0;
    for (int i = 0; i < 64; i++) begin
      fb = c[0] ^ data_i[i];
      c  = {1'b0, c[31:1]} ^ (fb ? Poly : 32'h0);
    end
    crc_o = c;
  end

endmodule

// File: rtl/xgmii_tx_engine.sv
// XGMII transmit framer: builds Ethernet/IPv4/UDP frames carrying the link magic,
// command dword and FIFO payload, with IP header checksum and FCS computed inline.
module xgmii_tx_engine
  import xgmii_pkg::*;
#(
  parameter logic [15:0] UDP_PORT = 16'd3422,
  parameter logic [31:0] MAGIC    = 32'h4E554D41,
  parameter logic [7:0]  IP_TTL   = 8'd64
) (
  input  logic        xgmii_clk,
  input  logic        sys_rst_n,
  output logic [7:0]  xgmii_txc,
  output logic [63:0] xgmii_txd,
  input  logic [47:0] if_macaddr,
  input  logic [31:0] if_v4addr,
  input  logic [47:0] dest_macaddr,
  input  logic [31:0] dest_v4addr,
  input  logic        tx_req,
  input  logic [9:0]  tx_len,
  input  logic        tx_bit64,
  input  logic [63:0] tx_addr,
  input  logic [63:0] dout,
  input  logic        empty,
  output logic        rd_en,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_underrun,
  output logic [7:0]  xgmii_pktcount
);

  tx_state_e   state_q;
  logic [2:0]  hdr_idx_q;
  logic [8:0]  pay_cnt_q;
  logic [47:0] smac_q, dmac_q;
  logic [31:0] sip_q, dip_q;
  logic [9:0]  len_q;
  logic        bit64_q;
  logic [63:0] addr_q;
  logic [15:0] csum_q;
  logic [31:0] crc_q;
  logic [63:0] txd_q;
  logic [7:0]  txc_q;
  logic        done_q, und_q, busy_q;
  logic [7:0]  cnt_q;

  logic [15:0] pay_bytes, ip_len, udp_len, csum_fold, csum_d;
  logic [31:0] csum_sum;
  logic [16:0] csum_s1;
  logic [31:0] cmd_word;
  logic [63:0] hdr_beat, crc_in;
  logic [31:0] crc_next;

  always_comb begin
    pay_bytes = {4'd0, len_q[9:1], 3'd0};
    ip_len    = 16'd50 + pay_bytes;
    udp_len   = 16'd30 + pay_bytes;
    csum_sum  = 32'h4500 + {16'h0, ip_len} + 32'h4000 + {16'h0, IP_TTL, IpProtoUdp}
              + {16'h0, sip_q[31:16]} + {16'h0, sip_q[15:0]}
              + {16'h0, dip_q[31:16]} + {16'h0, dip_q[15:0]};
    csum_s1   = {1'b0, csum_sum[15:0]} + {1'b0, csum_sum[31:16]};
    // A second carry cannot arise: the sum of ten 16-bit words stays below 2^20.
    csum_fold = csum_s1[15:0] + {15'd0, csum_s1[16]};
    csum_d    = ~csum_fold;
    cmd_word  = {2'b00, bit64_q, 19'd0, len_q};
  end

  always_comb begin
    hdr_beat = IdleBeat;
    unique case (hdr_idx_q)
      BeatMac:    hdr_beat = wire2lanes({dmac_q, smac_q[47:32]});
      BeatMacEth: hdr_beat = wire2lanes({smac_q[31:0], EthTypeIpv4, 8'h45, 8'h00});
      BeatIp0:    hdr_beat = wire2lanes({ip_len, 16'h0000, 16'h4000, IP_TTL, IpProtoUdp});
      BeatIp1:    hdr_beat = wire2lanes({csum_q, sip_q, dip_q[31:16]});
      BeatIpUdp:  hdr_beat = wire2lanes({dip_q[15:0], UDP_PORT, UDP_PORT, udp_len});
      BeatMagic:  hdr_beat = wire2lanes({16'h0000, MAGIC, 16'h0000});
      // Command dword goes out raw in lanes 0-3; the address half is network order.
      BeatCmd:    hdr_beat = wire2lanes({32'h0, addr_q[31:0]}) | {32'h0, cmd_word};
      BeatAddr:   hdr_beat = wire2lanes({addr_q[63:32], 32'h0});
      default:    hdr_beat = IdleBeat;
    endcase
  end

  assign crc_in = (state_q == StPay) ? dout : hdr_beat;

  crc32_d64 u_crc (
    .crc_i  (crc_q),
    .data_i (crc_in),
    .crc_o  (crc_next)
  );

  // FWFT FIFO: the pop must coincide with the cycle the word is taken.
  assign rd_en = (state_q == StPay) && !empty;

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      hdr_idx_q <= 3'd0;
      pay_cnt_q <= 9'd0;
      smac_q    <= 48'h0;
      dmac_q    <= 48'h0;
      sip_q     <= 32'h0;
      dip_q     <= 32'h0;
      len_q     <= 10'd0;
      bit64_q   <= 1'b0;
      addr_q    <= 64'h0;
      csum_q    <= 16'h0;
      crc_q     <= 32'hFFFFFFFF;
      txd_q     <= IdleBeat;
      txc_q     <= 8'hFF;
      done_q    <= 1'b0;
      und_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      done_q <= 1'b0;
      und_q  <= 1'b0;
      busy_q <= (state_q != StIdle) || tx_req;
      unique case (state_q)
        StIdle: begin
          txd_q <= IdleBeat;
          txc_q <= 8'hFF;
          if (tx_req) begin
            smac_q  <= if_macaddr;
            dmac_q  <= dest_macaddr;
            sip_q   <= if_v4addr;
            dip_q   <= dest_v4addr;
            len_q   <= tx_len;
            bit64_q <= tx_bit64;
            addr_q  <= tx_addr;
            state_q <= StCsum;
          end
        end
        StCsum: begin
          txd_q   <= IdleBeat;
          txc_q   <= 8'hFF;
          csum_q  <= csum_d;
          state_q <= StPre;
        end
        StPre: begin
          txd_q     <= wire2lanes({XgStart, {6{XgPre}}, XgSfd});
          txc_q     <= 8'h01;
          crc_q     <= 32'hFFFFFFFF;
          hdr_idx_q <= 3'd0;
          state_q   <= StHdr;
        end
        StHdr: begin
          txd_q     <= hdr_beat;
          txc_q     <= 8'h00;
          crc_q     <= crc_next;
          hdr_idx_q <= hdr_idx_q + 3'd1;
          if (hdr_idx_q == BeatAddr) begin
            pay_cnt_q <= len_q[9:1];
            state_q   <= (len_q[9:1] != 9'd0) ? StPay : StFcs;
          end
        end
        StPay: begin
          if (empty) begin
            txd_q   <= ErrBeat;
            txc_q   <= 8'hFF;
            und_q   <= 1'b1;
            state_q <= StErr;
          end else begin
            txd_q     <= dout;
            txc_q     <= 8'h00;
            crc_q     <= crc_next;
            pay_cnt_q <= pay_cnt_q - 9'd1;
            if (pay_cnt_q == 9'd1) state_q <= StFcs;
          end
        end
        StFcs: begin
          txd_q   <= {{3{XgIdle}}, XgTerm, ~crc_q};
          txc_q   <= 8'hF0;
          done_q  <= 1'b1;
          cnt_q   <= cnt_q + 8'd1;
          state_q <= StIfg;
        end
        StErr: begin
          txd_q   <= {{7{XgIdle}}, XgTerm};
          txc_q   <= 8'hFF;
          state_q <= StIfg;
        end
        StIfg: begin
          txd_q   <= IdleBeat;
          txc_q   <= 8'hFF;
          state_q <= StIdle;
        end
        default: begin
          txd_q   <= IdleBeat;
          txc_q   <= 8'hFF;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign xgmii_txd      = txd_q;
  assign xgmii_txc      = txc_q;
  assign tx_busy        = busy_q;
  assign tx_done        = done_q;
  assign tx_underrun    = und_q;
  assign xgmii_pktcount = cnt_q;

endmodule

// File: tb/tb_xgmii_tx_engine.sv
// Directed bench for xgmii_tx_engine: each wire beat is logged at the falling edge and
// compared against a byte-level frame model with its own checksum and CRC.
module tb_xgmii_tx_engine;

  localparam logic [47:0] Dmac  = 48'h02_00_00_00_00_02;
  localparam logic [47:0] Smac  = 48'h02_00_00_00_00_01;
  localparam logic [31:0] Sip   = 32'h0A000001;
  localparam logic [31:0] Dip   = 32'h0A000002;
  localparam logic [31:0] Magic = 32'h4E554D41;
  localparam logic [71:0] Idle72 = {8'hFF, 64'h0707070707070707};

  logic        xgmii_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  xgmii_txc;
  logic [63:0] xgmii_txd;
  logic [47:0] if_macaddr, dest_macaddr;
  logic [31:0] if_v4addr, dest_v4addr;
  logic        tx_req, tx_bit64, empty, rd_en, tx_busy, tx_done, tx_underrun;
  logic [9:0]  tx_len;
  logic [63:0] tx_addr, dout;
  logic [7:0]  xgmii_pktcount;

  xgmii_tx_engine #(
    .UDP_PORT (16'd3422),
    .MAGIC    (Magic),
    .IP_TTL   (8'd64)
  ) dut (
    .xgmii_clk      (xgmii_clk),
    .sys_rst_n      (sys_rst_n),
    .xgmii_txc      (xgmii_txc),
    .xgmii_txd      (xgmii_txd),
    .if_macaddr     (if_macaddr),
    .if_v4addr      (if_v4addr),
    .dest_macaddr   (dest_macaddr),
    .dest_v4addr    (dest_v4addr),
    .tx_req         (tx_req),
    .tx_len         (tx_len),
    .tx_bit64       (tx_bit64),
    .tx_addr        (tx_addr),
    .dout           (dout),
    .empty          (empty),
    .rd_en          (rd_en),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .tx_underrun    (tx_underrun),
    .xgmii_pktcount (xgmii_pktcount)
  );

  always #5 xgmii_clk = ~xgmii_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] fifo[$];
  logic        pop_pend = 1'b0;
  logic        hold_req = 1'b0;
  logic [63:0] lg_d [0:63];
  logic [7:0]  lg_c [0:63];
  logic        lg_b [0:63];
  logic        lg_done [0:63];
  logic        lg_und [0:63];
  int          nlog, n_rd, n_done, n_und;
  logic [7:0]  mb[$];
  logic [63:0] pl [0:3];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    empty = (fifo.size() == 0);
    dout  = (fifo.size() > 0) ? fifo[0] : 64'h0;
  endtask

  task automatic step();
    @(posedge xgmii_clk);
    #1;
    if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
    drive_fifo();
    if (!hold_req) tx_req = 1'b0;
    @(negedge xgmii_clk);
    if (nlog < 64) begin
      lg_d[nlog]    = xgmii_txd;
      lg_c[nlog]    = xgmii_txc;
      lg_b[nlog]    = tx_busy;
      lg_done[nlog] = tx_done;
      lg_und[nlog]  = tx_underrun;
    end
    nlog++;
    if (rd_en) n_rd++;
    if (tx_done) n_done++;
    if (tx_underrun) n_und++;
    pop_pend = rd_en;
  endtask

  task automatic set_ids();
    if_macaddr = Smac; dest_macaddr = Dmac; if_v4addr = Sip; dest_v4addr = Dip;
  endtask

  // Accept happens at the first step's rising edge; log[2] then holds the start beat.
  task automatic do_frame(input logic [9:0] len, input logic b64, input logic [63:0] addr,
                          input int ncyc, input logic hold);
    set_ids();
    tx_len = len; tx_bit64 = b64; tx_addr = addr;
    tx_req = 1'b1; hold_req = hold;
    nlog = 0; n_rd = 0; n_done = 0; n_und = 0;
    step();
    if (!hold) begin
      tx_len = 10'h3FE; tx_bit64 = ~b64; tx_addr = ~addr;
      if_macaddr = ~Smac; dest_macaddr = ~Dmac; if_v4addr = ~Sip; dest_v4addr = ~Dip;
    end
    repeat (ncyc - 1) step();
  endtask

  function automatic logic [15:0] ip_csum(input logic [15:0] tot);
    logic [31:0] s;
    s = 32'h4500 + tot + 32'h4000 + 32'h4011 + Sip[31:16] + Sip[15:0] + Dip[31:16] + Dip[15:0];
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic push16(input logic [15:0] v);
    mb.push_back(v[15:8]); mb.push_back(v[7:0]);
  endtask

  task automatic push32(input logic [31:0] v);
    push16(v[31:16]); push16(v[15:0]);
  endtask

  task automatic build_model(input logic [9:0] len, input logic b64, input logic [63:0] addr,
                             input int nw);
    logic [15:0] tot, ulen;
    logic [31:0] cmd;
    tot  = 16'd50 + 16'(8 * len[9:1]);
    ulen = 16'd30 + 16'(8 * len[9:1]);
    cmd  = 32'h0; cmd[29] = b64; cmd[9:0] = len;
    mb.delete();
    push16(Dmac[47:32]); push32(Dmac[31:0]); push16(Smac[47:32]); push32(Smac[31:0]);
    push16(16'h0800); push16(16'h4500);
    push16(tot); push16(16'h0000); push16(16'h4000); push16(16'h4011);
    push16(ip_csum(tot)); push32(Sip); push32(Dip);
    push16(16'h0D5E); push16(16'h0D5E); push16(ulen);
    push16(16'h0000); push32(Magic); push16(16'h0000);
    for (int i = 0; i < 4; i++) mb.push_back(cmd[8*i +: 8]);
    push32(addr[31:0]); push32(addr[63:32]); push32(32'h0);
    for (int w = 0; w < nw; w++)
      for (int i = 0; i < 8; i++) mb.push_back(pl[w][8*i +: 8]);
  endtask

  function automatic logic [63:0] mbeat(input int j);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mb[(j-1)*8 + i];
    return r;
  endfunction

  function automatic logic [31:0] model_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (mb[k]) begin
      c = c ^ {24'h0, mb[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic check_beats(input string fid, input int base, input int nb);
    chk({fid, "_start"}, {lg_c[base], lg_d[base]}, {8'h01, 64'hD5555555555555FB});
    for (int j = 1; j <= nb; j++)
      chk($sformatf("%s_beat%0d", fid, j), {lg_c[base+j], lg_d[base+j]}, {8'h00, mbeat(j)});
  endtask

  function automatic logic [71:0] term72();
    return {8'hF0, 24'h070707, 8'hFD, model_fcs()};
  endfunction

  int t1, s2, gap;

  initial begin
    sys_rst_n = 1'b0; tx_req = 1'b0; tx_len = 10'd0; tx_bit64 = 1'b0; tx_addr = 64'h0;
    set_ids();
    nlog = 0; n_rd = 0; n_done = 0; n_und = 0;
    drive_fifo();

    // Reset idle
    repeat (3) step();
    chk("rst_idle", {xgmii_txc, xgmii_txd}, Idle72);
    chk("rst_flags", {67'h0, rd_en, tx_busy, tx_done, tx_underrun, 1'b0}, 72'h0);
    chk("rst_cnt", {64'h0, xgmii_pktcount}, 72'h0);
    sys_rst_n = 1'b1;
    repeat (20) step();
    chk("idle20", {xgmii_txc, xgmii_txd}, Idle72);
    chk("idle20_busy", {71'h0, tx_busy}, 72'h0);
    chk("idle20_cnt", {64'h0, xgmii_pktcount}, 72'h0);

    // Zero-length frame
    do_frame(10'd0, 1'b0, 64'h1234, 16, 1'b0);
    build_model(10'd0, 1'b0, 64'h1234, 0);
    chk("z_busy_k1", {71'h0, lg_b[1]}, 72'h1);
    chk("z_idle_k1", {lg_c[1], lg_d[1]}, Idle72);
    check_beats("z", 2, 8);
    chk("z_ethertype", {56'h0, lg_d[4][47:32]}, {56'h0, 16'h0008});
    chk("z_dport", {56'h0, lg_d[7][47:32]}, {56'h0, 16'h5E0D});
    chk("z_udplen", {56'h0, lg_d[7][63:48]}, {56'h0, 16'h1E00});
    chk("z_iplen", {56'h0, lg_d[5][15:0]}, {56'h0, 16'h3200});
    chk("z_ipcsum", {56'h0, lg_d[6][15:0]}, {56'h0, 16'hB926});
    chk("z_term", {lg_c[11], lg_d[11]}, term72());
    chk("z_done_pos", {71'h0, lg_done[11]}, 72'h1);
    chk("z_ifg", {lg_c[12], lg_d[12]}, Idle72);
    chk("z_busy_ifg", {70'h0, lg_b[12], lg_b[13]}, 72'h2);
    chk("z_counts", {40'h0, 8'(n_rd), 8'(n_done), 8'(n_und), xgmii_pktcount}, {40'h0, 32'h00010001});

    // Payload frame, two words
    pl[0] = 64'h1122334455667788; pl[1] = 64'h99AABBCCDDEEFF00;
    fifo.push_back(pl[0]); fifo.push_back(pl[1]); drive_fifo();
    do_frame(10'd4, 1'b1, 64'hDEADBEEF00C0FFEE, 16, 1'b0);
    build_model(10'd4, 1'b1, 64'hDEADBEEF00C0FFEE, 2);
    check_beats("p", 2, 10);
    chk("p_wordA", {8'h0, lg_d[11]}, {8'h0, 64'h1122334455667788});
    chk("p_wordB", {8'h0, lg_d[12]}, {8'h0, 64'h99AABBCCDDEEFF00});
    chk("p_udplen", {56'h0, lg_d[7][63:48]}, {56'h0, 16'h2E00});
    chk("p_iplen", {56'h0, lg_d[5][15:0]}, {56'h0, 16'h4200});
    chk("p_ipcsum", {56'h0, lg_d[6][15:0]}, {56'h0, 16'hA926});
    chk("p_term", {lg_c[13], lg_d[13]}, term72());
    chk("p_counts", {40'h0, 8'(n_rd), 8'(n_done), 8'(n_und), xgmii_pktcount}, {40'h0, 32'h02010002});

    // Underrun: three words expected, one supplied
    pl[0] = 64'hA5A5A5A55A5A5A5A;
    fifo.push_back(pl[0]); drive_fifo();
    do_frame(10'd6, 1'b0, 64'h0000000000000040, 16, 1'b0);
    build_model(10'd6, 1'b0, 64'h0000000000000040, 1);
    check_beats("u", 2, 9);
    chk("u_errbeat", {lg_c[12], lg_d[12]}, {8'hFF, 64'hFEFEFEFEFEFEFEFE});
    chk("u_und_pos", {71'h0, lg_und[12]}, 72'h1);
    chk("u_termbeat", {lg_c[13], lg_d[13]}, {8'hFF, 64'h07070707070707FD});
    chk("u_ifg", {lg_c[14], lg_d[14]}, Idle72);
    chk("u_counts", {40'h0, 8'(n_rd), 8'(n_done), 8'(n_und), xgmii_pktcount}, {40'h0, 32'h01000102});

    // Back-to-back with tx_req held
    do_frame(10'd0, 1'b0, 64'h1234, 16, 1'b1);
    hold_req = 1'b0;
    repeat (14) step();
    build_model(10'd0, 1'b0, 64'h1234, 0);
    t1 = -1; s2 = -1;
    for (int i = 0; i < 30; i++) if (t1 < 0 && lg_c[i] == 8'hF0) t1 = i;
    if (t1 >= 0)
      for (int i = t1 + 1; i < 30; i++)
        if (s2 < 0 && lg_c[i] == 8'h01 && lg_d[i][7:0] == 8'hFB) s2 = i;
    chk("b_found", {71'h0, (t1 >= 0) && (s2 > t1)}, 72'h1);
    gap = s2 - t1 - 1;
    chk("b_gap_range", {71'h0, (gap >= 1) && (gap <= 3)}, 72'h1);
    if (t1 >= 0 && s2 > t1) begin
      for (int i = t1 + 1; i < s2; i++) chk($sformatf("b_gap%0d", i), {lg_c[i], lg_d[i]}, Idle72);
      check_beats("b2", s2, 8);
      chk("b2_term", {lg_c[s2+9], lg_d[s2+9]}, term72());
    end
    chk("b_counts", {48'h0, 8'(n_done), 8'(n_und), xgmii_pktcount}, {48'h0, 24'h020004});
    chk("b_idle_end", {xgmii_txc, xgmii_txd, 7'h0, tx_busy}, {Idle72[71:0], 8'h0} >> 8 << 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
